// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/gmii_tx_sched_if.sv
// Requester-side bus: two requesters, each with a byte stream and a grant.
interface gmii_tx_sched_if;
    logic [1:0]      req_i;
    logic [1:0][7:0] data_i;
    logic [1:0]      valid_i;
    logic [1:0]      last_i;
    logic [1:0]      ready_o;
    logic [1:0]      gnt_o;

    modport master (output req_i, data_i, valid_i, last_i, input ready_o, gnt_o);
    modport slave  (input req_i, data_i, valid_i, last_i, output ready_o, gnt_o);
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 (reflected, IEEE 802.3) next-state function.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    // Fold the byte in, then eight reflected shift steps (LSB first)
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        crc_out = c;
    end
endmodule

// File: rtl/gmii_tx_sched.sv
// Two-requester round-robin GMII transmit scheduler and frame builder.
module gmii_tx_sched
    import gmii_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514,
    parameter int CNT_W       = 16
) (
    input  logic             txck_i,
    input  logic             rst_i,
    gmii_tx_sched_if.slave   req_if,
    output logic [7:0]       txd_o,
    output logic             txctl_o,
    output logic             busy_o,
    output logic             abort_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] abort_cnt_o
);
    localparam logic [15:0] MIN_C    = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_C    = 16'(MAX_PAYLOAD);
    localparam logic [15:0] PRE_C    = 16'(PREAMBLE_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;      // preamble / payload / FCS index / IFG count
    logic [31:0]      crc_q, crc_d, crc_nx, fcs;
    logic [1:0]       gnt_q, gnt_d;
    logic             ptr_q, ptr_d;      // index of the requester served last
    logic             g;
    logic [7:0]       cur_data, crc_din, txd_d;
    logic             cur_valid, cur_last, txctl_d, abort_d;
    logic [CNT_W-1:0] fcnt_d, acnt_d;

    assign g         = gnt_q[1];
    assign cur_data  = req_if.data_i[g];
    assign cur_valid = req_if.valid_i[g];
    assign cur_last  = req_if.last_i[g];
    assign crc_din   = (state_q == ST_PAD) ? 8'h00 : cur_data;
    assign fcs       = ~crc_q;

    assign req_if.gnt_o   = gnt_q;
    assign req_if.ready_o = gnt_q & {2{state_q inside {ST_SFD, ST_PAY, ST_DRAIN}}};
    assign busy_o         = (state_q != ST_IDLE);

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_din),
        .crc_out (crc_nx)
    );

    // Next-state, wire byte, CRC and counter updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        txd_d   = txd_o;
        txctl_d = txctl_o;
        abort_d = 1'b0;
        fcnt_d  = frame_cnt_o;
        acnt_d  = abort_cnt_o;
        case (state_q)
            ST_IDLE: if (|req_if.req_i) begin
                // Prefer the requester not served last
                if (ptr_q) gnt_d = req_if.req_i[0] ? 2'b01 : 2'b10;
                else       gnt_d = req_if.req_i[1] ? 2'b10 : 2'b01;
                txctl_d = 1'b1;
                txd_d   = PREAMBLE_BYTE;
                cnt_d   = 16'd1;
                crc_d   = CRC_INIT;
                state_d = ST_PRE;
            end
            ST_PRE: begin
                if (cnt_q == PRE_C) begin
                    txd_d   = SFD_BYTE;
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SFD, ST_PAY: begin
                // Underrun, or an over-length byte that is swallowed silently
                if (!cur_valid || cnt_q == MAX_C) begin
                    txctl_d = 1'b0;
                    txd_d   = 8'h00;
                    abort_d = 1'b1;
                    acnt_d  = abort_cnt_o + CNT_W'(1);
                    cnt_d   = '0;
                    state_d = (cur_valid && cur_last) ? ST_IFG : ST_DRAIN;
                end else begin
                    txd_d   = cur_data;
                    crc_d   = crc_nx;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_PAY;
                    if (cur_last) begin
                        if (cnt_q + 16'd1 < MIN_C) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            ST_PAD: begin
                txd_d = 8'h00;
                crc_d = crc_nx;
                if (cnt_q + 16'd1 == MIN_C) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_FCS: begin
                txd_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q[1:0] == 2'd3) begin
                    fcnt_d  = frame_cnt_o + CNT_W'(1);
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DRAIN: if (cur_valid && cur_last) begin
                cnt_d   = '0;
                state_d = ST_IFG;
            end
            ST_IFG: begin
                txctl_d = 1'b0;
                txd_d   = 8'h00;
                if (cnt_q == IFG_LAST) begin
                    gnt_d   = 2'b00;
                    ptr_d   = g;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge txck_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            crc_q       <= CRC_INIT;
            gnt_q       <= 2'b00;
            ptr_q       <= 1'b1;
            txd_o       <= 8'h00;
            txctl_o     <= 1'b0;
            abort_o     <= 1'b0;
            frame_cnt_o <= '0;
            abort_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            txd_o       <= txd_d;
            txctl_o     <= txctl_d;
            abort_o     <= abort_d;
            frame_cnt_o <= fcnt_d;
            abort_cnt_o <= acnt_d;
        end
    end
endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: randomized frames against a wire-image reference model.
module tb_gmii_tx_sched;
    import gmii_pkg::*;

    localparam int MINP = 60;
    localparam int MAXP = 1514;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] gap;   // valid drops for one cycle after this many bytes (0 = never)
        logic [7:0]  seed;
    } fdesc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    gmii_tx_sched_if bus ();
    logic [7:0]  txd;
    logic        txctl, busy, abrt;
    logic [15:0] fcnt, acnt;

    gmii_tx_sched #(
        .IFG_BYTES   (12),
        .MIN_PAYLOAD (MINP),
        .MAX_PAYLOAD (MAXP),
        .CNT_W       (16)
    ) dut (
        .txck_i      (clk),
        .rst_i       (rst),
        .req_if      (bus),
        .txd_o       (txd),
        .txctl_o     (txctl),
        .busy_o      (busy),
        .abort_o     (abrt),
        .frame_cnt_o (fcnt),
        .abort_cnt_o (acnt)
    );

    int checks = 0;
    int errors = 0;

    fdesc_t     fq [2][$];
    fdesc_t     cur [2];
    logic       act [2];
    logic       gap_used [2];
    int         idx [2];
    logic [7:0] expq [2][$];
    int         elen [2][$];
    int         exp_frames, exp_aborts;

    logic [7:0] cap [$];
    logic       prev_t, have_prev, discard;
    int         own, low_run, nab, ohbad, rdybad, r1cnt;
    int         gap_log [$];
    int         own_log [$];
    logic [1:0] xf, xg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 over a whole byte sequence
    function automatic logic [31:0] crc32(input logic [7:0] b [$]);
        logic [31:0] c;
        logic        fb;
        c = CRC_INIT;
        foreach (b[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ CRC_POLY_REFL;
            end
        return ~c;
    endfunction

    // Queue a frame for requester r and predict its wire image and outcome
    task automatic enqueue(input int r, input int len, input int gap, input logic [7:0] seed);
        logic [7:0]  pay [$];
        logic [31:0] f;
        fdesc_t      d;
        int          ntx;
        bit          ab;
        d.len  = 16'(len);
        d.gap  = 16'(gap);
        d.seed = seed;
        fq[r].push_back(d);
        ab  = (gap > 0 && gap < len) || len > MAXP;
        ntx = (gap > 0 && gap < len) ? gap : ((len > MAXP) ? MAXP : len);
        for (int i = 0; i < PREAMBLE_LEN; i++) expq[r].push_back(PREAMBLE_BYTE);
        expq[r].push_back(SFD_BYTE);
        for (int i = 0; i < ntx; i++) pay.push_back(seed + 8'(i));
        if (!ab) begin
            while (pay.size() < MINP) pay.push_back(8'h00);
            f = crc32(pay);
            for (int k = 0; k < 4; k++) pay.push_back(f[8*k +: 8]);
            exp_frames++;
        end else begin
            exp_aborts++;
        end
        foreach (pay[i]) expq[r].push_back(pay[i]);
        elen[r].push_back(PREAMBLE_LEN + 1 + pay.size());
    endtask

    task automatic end_frame();
        int n, nbad;
        logic [7:0] e;
        if (discard) begin
            discard = 1'b0;
        end else if (elen[own].size() == 0) begin
            chk("unexpected_frame", 1, 0);
        end else begin
            n = elen[own].pop_front();
            chk("frame_len", cap.size(), n);
            nbad = 0;
            for (int i = 0; i < n; i++) begin
                e = expq[own].pop_front();
                if (i >= cap.size() || cap[i] !== e) nbad++;
            end
            chk("frame_bytes", nbad, 0);
        end
        have_prev = 1'b1;
    endtask

    // Observe outputs mid-cycle
    task automatic sample();
        @(negedge clk);
        if (txctl && !prev_t) begin
            own = int'(bus.gnt_o[1]);
            own_log.push_back(own);
            if (have_prev) gap_log.push_back(low_run);
            cap.delete();
        end
        if (txctl) begin
            cap.push_back(txd);
            low_run = 0;
        end else begin
            low_run++;
        end
        if (!txctl && prev_t) end_frame();
        prev_t = txctl;
        if (abrt) nab++;
        if (bus.gnt_o == 2'b11) ohbad++;
        if ((bus.ready_o & ~bus.gnt_o) != 2'b00) rdybad++;
        if (bus.ready_o[1]) r1cnt++;
        xf = bus.valid_i & bus.ready_o;
        xg = ~bus.valid_i & bus.ready_o;
    endtask

    // Requester behaviour: hold req and the current byte until accepted
    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (act[r]) begin
                if (xf[r]) idx[r]++;
                if (xg[r]) gap_used[r] = 1'b1;
                if (idx[r] == int'(cur[r].len)) act[r] = 1'b0;
            end
            if (!act[r] && fq[r].size() > 0) begin
                cur[r]      = fq[r].pop_front();
                act[r]      = 1'b1;
                idx[r]      = 0;
                gap_used[r] = 1'b0;
            end
            bus.req_i[r]   = act[r];
            bus.valid_i[r] = act[r] && !(cur[r].gap != 0 && idx[r] == int'(cur[r].gap) && !gap_used[r]);
            bus.data_i[r]  = cur[r].seed + 8'(idx[r]);
            bus.last_i[r]  = act[r] && (idx[r] == int'(cur[r].len) - 1);
        end
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || prev_t || act[0] || act[1] || fq[0].size() > 0 || fq[1].size() > 0)
                   && n < budget);
        chk({"timeout_", tag}, 64'(n < budget), 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk(tag, {txd, txctl, bus.gnt_o, bus.ready_o, busy, abrt, fcnt, acnt}, 64'd0);
    endtask

    initial begin
        int n, bad;
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; gap_used[r] = 1'b0; idx[r] = 0; cur[r] = '0;
        end
        bus.req_i = '0; bus.valid_i = '0; bus.last_i = '0; bus.data_i = '0;
        prev_t = 1'b0; have_prev = 1'b0; discard = 1'b0;
        own = 0; low_run = 0; nab = 0; ohbad = 0; rdybad = 0; r1cnt = 0;
        exp_frames = 0; exp_aborts = 0; xf = '0; xg = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // Minimum-size frame, incrementing payload
        enqueue(0, 60, 0, 8'h00);
        wait_done("t1", 400);
        chk("t1_frame_cnt", fcnt, exp_frames);

        // Short frame from requester 1 needs padding
        r1cnt = 0;
        enqueue(1, 10, 0, 8'($urandom));
        wait_done("t2", 400);
        chk("t2_ready1_cycles", r1cnt, 10);
        chk("t2_frame_cnt", fcnt, exp_frames);

        // Both requesters contending for three frames each
        own_log.delete();
        gap_log.delete();
        for (int k = 0; k < 3; k++) begin
            enqueue(0, $urandom_range(20, 100), 0, 8'($urandom));
            enqueue(1, $urandom_range(20, 100), 0, 8'($urandom));
        end
        wait_done("t3", 3000);
        chk("t3_grant_count", own_log.size(), 6);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (k >= own_log.size() || own_log[k] != (k % 2)) bad++;
        chk("t3_grant_order", bad, 0);
        chk("t3_gap_count", gap_log.size(), 6);
        bad = 0;
        for (int k = 1; k < 6; k++)
            if (k >= gap_log.size() || gap_log[k] != 12) bad++;
        chk("t3_ifg_len", bad, 0);
        chk("t3_frame_cnt", fcnt, exp_frames);

        // Underrun after byte 20, last at byte 30
        n = int'(fcnt);
        enqueue(0, 30, 20, 8'($urandom));
        wait_done("t4", 400);
        chk("t4_abort_cnt", acnt, exp_aborts);
        chk("t4_abort_pulses", nab, 1);
        chk("t4_frame_cnt", fcnt, n);

        // Oversize frame: 1515th byte carries last
        enqueue(1, 1515, 0, 8'($urandom));
        wait_done("t5", 4000);
        chk("t5_abort_cnt", acnt, exp_aborts);
        chk("t5_abort_pulses", nab, 2);
        chk("t5_frame_cnt", fcnt, exp_frames);

        // Reset in the middle of the payload
        enqueue(0, 60, 0, 8'($urandom));
        n = 0;
        while (idx[0] < 40 && n < 500) begin
            tick();
            n++;
        end
        chk("timeout_t6", 64'(n < 500), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; fq[r].delete(); expq[r].delete(); elen[r].delete();
        end
        bus.req_i = '0; bus.valid_i = '0; bus.last_i = '0;
        xf = '0; xg = '0;
        discard = prev_t;
        exp_frames = 0; exp_aborts = 0; nab = 0;
        @(negedge clk);
        check_reset_state("t6_reset_state");
        @(posedge clk);
        #1;
        own_log.delete();
        enqueue(1, $urandom_range(20, 80), 0, 8'($urandom));
        enqueue(0, $urandom_range(20, 80), 0, 8'($urandom));
        wait_done("t6b", 1000);
        chk("t6_first_grant", own_log.size() > 0 ? own_log[0] : -1, 0);
        chk("t6_second_grant", own_log.size() > 1 ? own_log[1] : -1, 1);
        chk("t6_frame_cnt", fcnt, exp_frames);

        chk("gnt_onehot", ohbad, 0);
        chk("ready_ungranted", rdybad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
